// File: rtl/instr_encoder_if.sv
// instr_encoder_if: descriptor stream, IMEM write bus and status of the
// RV32I instruction encoder. The loader side uses the master modport and
// the encoder uses the slave modport.
interface instr_encoder_if #(
  parameter int IMEM_DEPTH = 2048,
  parameter int ADDR_W     = $clog2(IMEM_DEPTH)
);
  // control and descriptor stream
  logic              start;
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_fmt;
  logic [6:0]        in_opcode;
  logic [2:0]        in_funct3;
  logic [6:0]        in_funct7;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [31:0]       in_imm;
  logic              in_last;
  // instruction memory write port
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  // status
  logic              busy;
  logic              done;
  logic [1:0]        err_code;
  logic [ADDR_W:0]   count;

  modport master (
    output start, in_valid, in_fmt, in_opcode, in_funct3, in_funct7,
           in_rd, in_rs1, in_rs2, in_imm, in_last,
    input  in_ready, imem_we, imem_addr, imem_wdata, busy, done, err_code, count
  );

  modport slave (
    input  start, in_valid, in_fmt, in_opcode, in_funct3, in_funct7,
           in_rd, in_rs1, in_rs2, in_imm, in_last,
    output in_ready, imem_we, imem_addr, imem_wdata, busy, done, err_code, count
  );
endinterface

// File: rtl/instr_encoder.sv
// instr_encoder: packs RV32I instruction descriptors into 32-bit words and
// writes them to instruction memory at consecutive word addresses.
// Optional feature macro: IMM_RANGE_CHECK_EN -- when defined, immediates that
// do not fit their format are rejected with err_code 1; when undefined the
// out-of-range bits are silently truncated by the field mapping.
module instr_encoder #(
  parameter int IMEM_DEPTH = 2048,
  parameter int BASE_ADDR  = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  instr_encoder_if.slave bus
);
  localparam int ADDR_W = $clog2(IMEM_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_ERR} state_t;

  localparam logic [2:0] FMT_U   = 3'd0;
  localparam logic [2:0] FMT_J   = 3'd1;
  localparam logic [2:0] FMT_I   = 3'd2;
  localparam logic [2:0] FMT_S   = 3'd3;
  localparam logic [2:0] FMT_B   = 3'd4;
  localparam logic [2:0] FMT_R   = 3'd5;
  localparam logic [2:0] FMT_SH  = 3'd6;
  localparam logic [2:0] FMT_ILL = 3'd7;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_IMM  = 2'd1;
  localparam logic [1:0] ERR_FULL = 2'd2;
  localparam logic [1:0] ERR_FMT  = 2'd3;

  localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W+1)'(IMEM_DEPTH);
  localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);

  state_t            r_state;
  logic              r_imem_we;
  logic [ADDR_W-1:0] r_imem_addr;
  logic [31:0]       r_imem_wdata;
  logic [ADDR_W:0]   r_count;
  logic [1:0]        r_err;
  logic              r_busy;
  logic              r_done;

  logic              w_ready;
  logic              w_accept;
  logic              w_imm_ok;
  logic [31:0]       w_imm;
  logic [31:0]       w_word;
  logic [ADDR_W:0]   w_count_inc;
  logic [ADDR_W-1:0] w_addr;

  // Ready depends only on state, fill level and start -- never on in_valid.
  assign w_ready     = (r_state == S_RUN) && !bus.start && (r_count < DEPTH_CNT);
  assign w_accept    = bus.in_valid && w_ready;
  assign w_imm       = bus.in_imm;
  assign w_count_inc = r_count + 1'b1;
  assign w_addr      = BASE + r_count[ADDR_W-1:0];

  // Pack the descriptor fields into the RV32I word for the selected format.
  always_comb begin
    w_word = 32'd0;
    case (bus.in_fmt)
      FMT_U:  w_word = {w_imm[31:12], bus.in_rd, bus.in_opcode};
      FMT_J:  w_word = {w_imm[20], w_imm[10:1], w_imm[11], w_imm[19:12],
                        bus.in_rd, bus.in_opcode};
      FMT_I:  w_word = {w_imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd,
                        bus.in_opcode};
      FMT_SH: w_word = {bus.in_funct7, w_imm[4:0], bus.in_rs1, bus.in_funct3,
                        bus.in_rd, bus.in_opcode};
      FMT_S:  w_word = {w_imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                        w_imm[4:0], bus.in_opcode};
      FMT_B:  w_word = {w_imm[12], w_imm[10:5], bus.in_rs2, bus.in_rs1,
                        bus.in_funct3, w_imm[4:1], w_imm[11], bus.in_opcode};
      FMT_R:  w_word = {bus.in_funct7, bus.in_rs2, bus.in_rs1, bus.in_funct3,
                        bus.in_rd, bus.in_opcode};
      default: w_word = 32'd0;
    endcase
  end

`ifdef IMM_RANGE_CHECK_EN
  // Check that the immediate survives the format's field mapping unchanged.
  always_comb begin
    w_imm_ok = 1'b1;
    case (bus.in_fmt)
      FMT_U:        w_imm_ok = (w_imm[11:0] == 12'd0);
      FMT_J:        w_imm_ok = (w_imm[31:20] == {12{w_imm[20]}}) && !w_imm[0];
      FMT_I, FMT_S: w_imm_ok = (w_imm[31:11] == {21{w_imm[11]}});
      FMT_B:        w_imm_ok = (w_imm[31:12] == {20{w_imm[12]}}) && !w_imm[0];
      FMT_SH:       w_imm_ok = (w_imm[31:5] == 27'd0);
      default:      w_imm_ok = 1'b1;
    endcase
  end
`else
  assign w_imm_ok = 1'b1;
`endif

  // Control FSM: accepts beats, drives the registered write port and status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_imem_we    <= 1'b0;
      r_imem_addr  <= '0;
      r_imem_wdata <= 32'd0;
      r_count      <= '0;
      r_err        <= ERR_NONE;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_imem_we <= 1'b0;
      if (bus.start) begin
        // start wins over any beat presented in the same cycle
        r_state <= S_RUN;
        r_count <= '0;
        r_err   <= ERR_NONE;
        r_busy  <= 1'b1;
        r_done  <= 1'b0;
      end else if (w_accept) begin
        if (bus.in_fmt == FMT_ILL) begin
          r_state <= S_ERR;
          r_err   <= ERR_FMT;
          r_busy  <= 1'b0;
        end else if (!w_imm_ok) begin
          r_state <= S_ERR;
          r_err   <= ERR_IMM;
          r_busy  <= 1'b0;
        end else begin
          r_imem_we    <= 1'b1;
          r_imem_addr  <= w_addr;
          r_imem_wdata <= w_word;
          r_count      <= w_count_inc;
          if (bus.in_last) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else if (w_count_inc == DEPTH_CNT) begin
            // this word filled IMEM; it is still written
            r_state <= S_ERR;
            r_err   <= ERR_FULL;
            r_busy  <= 1'b0;
          end
        end
      end
    end
  end

  assign bus.in_ready   = w_ready;
  assign bus.imem_we    = r_imem_we;
  assign bus.imem_addr  = r_imem_addr;
  assign bus.imem_wdata = r_imem_wdata;
  assign bus.count      = r_count;
  assign bus.err_code   = r_err;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed and randomized check of instr_encoder against a
// behavioural model (arithmetic field packing, immediate-generator decode).
module tb_instr_encoder;
  localparam int DEPTH  = 2048;
  localparam int SDEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_tests = 0;
  int n_fail  = 0;

  // model of the main encoder
  bit m_run, m_done;
  int m_count, m_err;

  always #5 clk = ~clk;

  instr_encoder_if #(.IMEM_DEPTH(DEPTH))  bus ();
  instr_encoder_if #(.IMEM_DEPTH(SDEPTH)) sbus ();

  instr_encoder #(.IMEM_DEPTH(DEPTH), .BASE_ADDR(0)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));
  instr_encoder #(.IMEM_DEPTH(SDEPTH), .BASE_ADDR(0)) dut_s (
    .clk(clk), .rst_n(rst_n), .bus(sbus));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] sx(input logic [31:0] v, input int b);
    logic [31:0] m;
    m = (32'h1 << b) - 32'h1;
    if (((v >> (b - 1)) & 32'h1) != 0) return v | ~m;
    return v & m;
  endfunction

  // Expected word, built with shifts and masks from the format table.
  function automatic logic [31:0] enc(input logic [2:0] fmt, input logic [6:0] opc,
      input logic [2:0] f3, input logic [6:0] f7, input logic [4:0] rd,
      input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] u);
    logic [31:0] o, a, b, c, d, e;
    o = 32'(opc); a = 32'(rd) << 7; b = 32'(f3) << 12; c = 32'(rs1) << 15;
    d = 32'(rs2) << 20; e = 32'(f7) << 25;
    case (fmt)
      3'd0: return (u & 32'hFFFFF000) | a | o;
      3'd1: return (((u >> 20) & 32'h1) << 31) | (((u >> 1) & 32'h3FF) << 21) |
                   (((u >> 11) & 32'h1) << 20) | (((u >> 12) & 32'hFF) << 12) | a | o;
      3'd2: return ((u & 32'hFFF) << 20) | c | b | a | o;
      3'd3: return (((u >> 5) & 32'h7F) << 25) | d | c | b | ((u & 32'h1F) << 7) | o;
      3'd4: return (((u >> 12) & 32'h1) << 31) | (((u >> 5) & 32'h3F) << 25) | d | c | b |
                   (((u >> 1) & 32'hF) << 8) | (((u >> 11) & 32'h1) << 7) | o;
      3'd5: return e | d | c | b | a | o;
      3'd6: return e | ((u & 32'h1F) << 20) | c | b | a | o;
      default: return 32'd0;
    endcase
  endfunction

  // Immediate generator: recover the immediate from a written word.
  function automatic logic [31:0] dec(input logic [2:0] fmt, input logic [31:0] w);
    case (fmt)
      3'd0: return w & 32'hFFFFF000;
      3'd1: return sx((((w >> 31) & 32'h1) << 20) | (((w >> 12) & 32'hFF) << 12) |
                      (((w >> 20) & 32'h1) << 11) | (((w >> 21) & 32'h3FF) << 1), 21);
      3'd2: return sx(w >> 20, 12);
      3'd3: return sx(((w >> 25) << 5) | ((w >> 7) & 32'h1F), 12);
      3'd4: return sx((((w >> 31) & 32'h1) << 12) | (((w >> 7) & 32'h1) << 11) |
                      (((w >> 25) & 32'h3F) << 5) | (((w >> 8) & 32'hF) << 1), 13);
      3'd6: return (w >> 20) & 32'h1F;
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit imm_ok(input logic [2:0] fmt, input logic [31:0] v);
`ifdef IMM_RANGE_CHECK_EN
    case (fmt)
      3'd0: return (v & 32'hFFF) == 0;
      3'd1: return sx(v, 21) == v && v[0] == 1'b0;
      3'd2, 3'd3: return sx(v, 12) == v;
      3'd4: return sx(v, 13) == v && v[0] == 1'b0;
      3'd6: return v < 32;
      default: return 1'b1;
    endcase
`else
    return (fmt != 3'd7);
`endif
  endfunction

  function automatic logic [31:0] rand_imm(input logic [2:0] fmt);
    logic [31:0] r;
    r = $urandom;
    case (fmt)
      3'd0: return r & 32'hFFFFF000;
      3'd1: return sx(r, 21) & ~32'h1;
      3'd2, 3'd3: return sx(r, 12);
      3'd4: return sx(r, 13) & ~32'h1;
      3'd6: return r & 32'h1F;
      default: return r;
    endcase
  endfunction

  // Present one descriptor for one cycle and check the result against the model.
  task automatic beat(input logic [2:0] fmt, input logic [6:0] opc, input logic [2:0] f3,
      input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
      input logic [4:0] rs2, input logic [31:0] imm, input bit last, input bit rt);
    logic [31:0] w;
    bit acc, wr;
    bus.in_fmt = fmt; bus.in_opcode = opc; bus.in_funct3 = f3; bus.in_funct7 = f7;
    bus.in_rd = rd; bus.in_rs1 = rs1; bus.in_rs2 = rs2; bus.in_imm = imm;
    bus.in_last = last; bus.in_valid = 1'b1;
    #1;
    acc = m_run;
    chk("in_ready", 32'(bus.in_ready), 32'(acc));
    w = enc(fmt, opc, f3, f7, rd, rs1, rs2, imm);
    tick();
    bus.in_valid = 1'b0;
    wr = 1'b0;
    if (acc) begin
      if (fmt == 3'd7) begin
        m_run = 1'b0; m_err = 3;
      end else if (!imm_ok(fmt, imm)) begin
        m_run = 1'b0; m_err = 1;
      end else begin
        wr = 1'b1;
        m_count++;
        if (last) begin
          m_run = 1'b0; m_done = 1'b1;
        end else if (m_count == DEPTH) begin
          m_run = 1'b0; m_err = 2;
        end
      end
    end
    chk("imem_we", 32'(bus.imem_we), 32'(wr));
    if (wr) begin
      chk("imem_addr", 32'(bus.imem_addr), 32'(m_count - 1));
      chk("imem_wdata", bus.imem_wdata, w);
      if (rt) chk("roundtrip", dec(fmt, bus.imem_wdata), imm);
    end
    chk("count", 32'(bus.count), 32'(m_count));
    chk("busy", 32'(bus.busy), 32'(m_run));
    chk("done", 32'(bus.done), 32'(m_done));
    chk("err_code", 32'(bus.err_code), 32'(m_err));
    $display("[TB] beat fmt=%0d imm=%08h acc=%0b wr=%0b addr=%0d data=%08h cnt=%0d err=%0d",
             fmt, imm, acc, wr, bus.imem_addr, bus.imem_wdata, bus.count, bus.err_code);
  endtask

  // Pulse start, optionally with a valid beat in the same cycle (never accepted).
  task automatic do_start(input bit with_valid);
    bus.start = 1'b1;
    bus.in_valid = with_valid;
    bus.in_fmt = 3'd2; bus.in_imm = $urandom; bus.in_last = 1'b0;
    #1;
    chk("start_ready", 32'(bus.in_ready), 32'd0);
    tick();
    bus.start = 1'b0;
    bus.in_valid = 1'b0;
    m_run = 1'b1; m_done = 1'b0; m_count = 0; m_err = 0;
    chk("start_we", 32'(bus.imem_we), 32'd0);
    chk("start_count", 32'(bus.count), 32'd0);
    chk("start_busy", 32'(bus.busy), 32'd1);
    chk("start_err", 32'(bus.err_code), 32'd0);
    $display("[TB] start with_valid=%0b busy=%0b count=%0d", with_valid, bus.busy, bus.count);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      tick();
      chk("idle_we", 32'(bus.imem_we), 32'd0);
    end
  endtask

  initial begin
    logic [2:0]  f;
    logic [31:0] im, w;
    bus.start = 1'b0; bus.in_valid = 1'b0; bus.in_fmt = '0; bus.in_opcode = '0;
    bus.in_funct3 = '0; bus.in_funct7 = '0; bus.in_rd = '0; bus.in_rs1 = '0;
    bus.in_rs2 = '0; bus.in_imm = '0; bus.in_last = 1'b0;
    sbus.start = 1'b0; sbus.in_valid = 1'b0; sbus.in_fmt = '0; sbus.in_opcode = '0;
    sbus.in_funct3 = '0; sbus.in_funct7 = '0; sbus.in_rd = '0; sbus.in_rs1 = '0;
    sbus.in_rs2 = '0; sbus.in_imm = '0; sbus.in_last = 1'b0;
    m_run = 1'b0; m_done = 1'b0; m_count = 0; m_err = 0;

    // reset state
    tick(); tick();
    chk("rst_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_we", 32'(bus.imem_we), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_addr", 32'(bus.imem_addr), 32'd0);
    chk("rst_wdata", bus.imem_wdata, 32'd0);
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_err", 32'(bus.err_code), 32'd0);
    rst_n = 1'b1;
    tick();

    // IDLE never accepts
    beat(3'd2, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd3, 1'b0, 1'b1);

    // test-plan I and B beats
    do_start(1'b1);
    beat(3'd2, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, -32'sd5, 1'b0, 1'b1);
    chk("tp_I_word", bus.imem_wdata, 32'hFFB00093);
    beat(3'd4, 7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, -32'sd8, 1'b1, 1'b1);
    chk("tp_B_word", bus.imem_wdata, 32'hFE208CE3);
    beat(3'd2, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd1, 1'b0, 1'b1);

    // test-plan J beat
    do_start(1'b0);
    beat(3'd1, 7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h800, 1'b0, 1'b1);
    chk("tp_J_word", bus.imem_wdata, 32'h001000EF);
    chk("tp_J_imm", dec(3'd1, bus.imem_wdata), 32'h00000800);

    // I immediate 2048: rejected with checks, truncated without
    beat(3'd2, 7'h13, 3'd0, 7'd0, 5'd2, 5'd3, 5'd0, 32'd2048, 1'b0, 1'b0);
`ifdef IMM_RANGE_CHECK_EN
    chk("imm2048_err", 32'(bus.err_code), 32'd1);
    chk("imm2048_ready", 32'(bus.in_ready), 32'd0);
`else
    chk("imm2048_hi", 32'(bus.imem_wdata[31:20]), 32'h800);
    chk("imm2048_err", 32'(bus.err_code), 32'd0);
`endif

    // illegal format latches err 3 until the next start
    do_start(1'b0);
    beat(3'd7, 7'h13, 3'd0, 7'd0, 5'd1, 5'd1, 5'd1, 32'd0, 1'b0, 1'b0);
    beat(3'd2, 7'h13, 3'd0, 7'd0, 5'd1, 5'd1, 5'd1, 32'd0, 1'b0, 1'b0);
    idle(1);

    // randomized stream with gaps, terminated by in_last
    do_start(1'b0);
    for (int i = 0; i < 80; i++) begin
      f = 3'($urandom_range(0, 6));
      im = rand_imm(f);
      beat(f, 7'($urandom), 3'($urandom), 7'($urandom), 5'($urandom), 5'($urandom),
           5'($urandom), im, (i == 79), (f != 3'd5));
      if ($urandom_range(0, 3) == 0) idle(1);
    end

    // start during the 2nd beat: beat dropped, pointer restarts
    do_start(1'b0);
    beat(3'd0, 7'h37, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345000, 1'b0, 1'b1);
    idle(1);
    do_start(1'b1);
    idle(1);
    beat(3'd5, 7'h33, 3'd0, 7'h20, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0, 1'b0);
    chk("restart_addr", 32'(bus.imem_addr), 32'd0);

    // reset mid-stream drops the write strobe immediately
    beat(3'd2, 7'h13, 3'd0, 7'd0, 5'd4, 5'd4, 5'd0, 32'd7, 1'b0, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("arst_we", 32'(bus.imem_we), 32'd0);
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_count", 32'(bus.count), 32'd0);
    chk("arst_wdata", bus.imem_wdata, 32'd0);
    m_run = 1'b0; m_done = 1'b0; m_count = 0; m_err = 0;
    tick();
    rst_n = 1'b1;
    tick();

    // small IMEM: 5 back-to-back beats, only 4 written, then err 2
    sbus.start = 1'b1;
    tick();
    sbus.start = 1'b0;
    chk("s_busy0", 32'(sbus.busy), 32'd1);
    for (int k = 0; k < 5; k++) begin
      im = rand_imm(3'd2);
      sbus.in_fmt = 3'd2; sbus.in_opcode = 7'h13; sbus.in_funct3 = 3'($urandom);
      sbus.in_rd = 5'($urandom); sbus.in_rs1 = 5'($urandom); sbus.in_imm = im;
      sbus.in_last = 1'b0; sbus.in_valid = 1'b1;
      #1;
      chk("s_in_ready", 32'(sbus.in_ready), 32'(k < 4));
      w = enc(3'd2, 7'h13, sbus.in_funct3, 7'd0, sbus.in_rd, sbus.in_rs1, 5'd0, im);
      tick();
      chk("s_imem_we", 32'(sbus.imem_we), 32'(k < 4));
      if (k < 4) begin
        chk("s_addr", 32'(sbus.imem_addr), 32'(k));
        chk("s_wdata", sbus.imem_wdata, w);
      end
      chk("s_count", 32'(sbus.count), 32'((k < 4) ? k + 1 : 4));
      chk("s_err", 32'(sbus.err_code), 32'((k >= 3) ? 2 : 0));
      chk("s_busy", 32'(sbus.busy), 32'(k < 3));
      $display("[TB] small beat %0d we=%0b addr=%0d cnt=%0d err=%0d",
               k, sbus.imem_we, sbus.imem_addr, sbus.count, sbus.err_code);
    end
    sbus.in_valid = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/instr_encoder.md
# instr_encoder

- Sequential RISC-V RV32I instruction encoder and program writer; the encode-side counterpart of the immediate generator.
- Accepts a stream of decoded instruction descriptors (format, opcode, funct fields, register indices, 32-bit immediate) over a valid/ready handshake.
- Packs each descriptor into a 32-bit instruction word and writes it into instruction memory at consecutive word addresses.
- Used by the boot/test loader to fill IMEM before the core is released from reset.

## Interface
- IMEM_DEPTH, 2048: instruction memory depth in words. ADDR_W = $clog2(IMEM_DEPTH).
- BASE_ADDR, 0: word address of the first write.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  pulse; clears pointer and error, enters RUN from any state.
- in_valid  in  1  descriptor valid.
- in_ready  out  1  descriptor accepted when in_valid && in_ready.
- in_fmt  in  3  0 U, 1 J, 2 I, 3 S, 4 B, 5 R, 6 I-shift, 7 illegal.
- in_opcode  in  7  opcode field.
- in_funct3  in  3  funct3 field.
- in_funct7  in  7  funct7 field (R, I-shift).
- in_rd, in_rs1, in_rs2  in  5 each  register indices.
- in_imm  in  32  immediate as a signed byte offset or value.
- in_last  in  1  final descriptor of the program.
- imem_we  out  1  one-cycle write strobe.
- imem_addr  out  ADDR_W  word address.
- imem_wdata  out  32  encoded instruction.
- busy  out  1  state == RUN.
- done  out  1  state == DONE.
- err_code  out  2  0 none, 1 immediate range/alignment, 2 IMEM full, 3 illegal fmt.
- count  out  ADDR_W+1  words written since start.

## Operation
- States and transitions:
  - IDLE: default after reset.
  - RUN: in_ready = !start.
  - DONE: entered after in_last is written.
  - ERR: error latched; in_ready = 0.
  - start moves any state to RUN, with count = 0 and err_code = 0. A start in the same cycle as in_valid does not accept the beat.
- Encoding (opc = in_opcode):
  - U: {imm[31:12], rd, opc}.
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opc}.
  - I: {imm[11:0], rs1, f3, rd, opc}.
  - I-shift: {funct7, imm[4:0], rs1, f3, rd, opc}.
  - S: {imm[11:5], rs2, rs1, f3, imm[4:0], opc}.
  - B: {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], opc}.
  - R: {funct7, rs2, rs1, f3, rd, opc}.
- Round-trip property: decoding any written word through the immediate generator returns in_imm, for every in-range immediate.
- On an accepted beat:
  - Encoded word registered into imem_wdata.
  - imem_addr = BASE_ADDR + count.
  - imem_we = 1 for one cycle.
  - count increments.
- in_last accepted: RUN → DONE.
- count reaches IMEM_DEPTH without in_last: RUN → ERR with err_code = 2. The last beat is still written.
- fmt 7 accepted: no write, err_code = 3, state ERR.
- Errors remain latched until the next start or reset.

## Timing
- Reset values:
  - state IDLE.
  - in_ready, imem_we, busy, done all 0.
  - imem_addr 0, imem_wdata 0, count 0, err_code 0.
- Reset mid-stream: returns to IDLE immediately. Any pending write is dropped; imem_we goes low asynchronously.
- Latency: 1 cycle from acceptance edge to imem_we high.
- Throughput: 1 word/cycle while in_valid is held.
- in_ready is combinational from state, count and start. It never depends on in_valid.
- done and err_code update on the same edge that loads the final write. The final imem_we is therefore visible in the first DONE/ERR cycle.
- count increments on the acceptance edge; the count output leads imem_we by 0 cycles.

## Configuration
- IMM_RANGE_CHECK_EN defined:
  - Accepted beats are rejected (no write, err_code = 1, state ERR) when in_imm does not fit the format. Limits:
    - I/S: signed 12-bit.
    - B: signed 13-bit and even.
    - J: signed 21-bit and even.
    - U: imm[11:0] must be 0.
    - I-shift: 0..31.
- Undefined: no range checks. Out-of-range bits are silently truncated per the field mapping, and err_code never takes value 1.

## Test plan
- start, then I beat: opc 0x13, f3 0, rd 1, rs1 0, imm −5 → imem_we at addr 0, wdata 0xFFB00093, count 1.
- B beat: opc 0x63, f3 0, rs1 1, rs2 2, imm −8, in_last → wdata 0xFE208CE3, done = 1 in the same cycle as imem_we.
- J beat: opc 0x6F, rd 1, imm 0x800 → wdata 0x001000EF. Feed the word to the immediate generator and confirm 0x00000800.
- I beat with imm 2048:
  - With IMM_RANGE_CHECK_EN: no write, err_code 1, in_ready 0.
  - Without it: wdata[31:20] = 0x800, err_code 0.
- IMEM_DEPTH = 4, 5 back-to-back beats, no in_last → writes to addr 0..3, err_code 2, 5th beat never accepted.
- Stream of 3 beats with in_valid gaps, start pulsed during the 2nd beat → 2nd beat not accepted, count restarts at 0, next write at addr 0.
